spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target_if.sv | 27 ++
 rtl/spi_target.sv | 163 ++++++++++++++++
 tb/tb_spi_target.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// SPI target bundle: the SPI pins plus the tx/rx word handshake.
// The slave modport is the target's view; master is the view of whatever drives it.
interface spi_target_if #(
  parameter int unsigned WIDTH = 8
);
  logic             spi_sck;
  logic             spi_cs_n;
  logic             spi_mosi;
  logic             spi_miso;
  logic             spi_miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun
  );
endinterface

// File: rtl/spi_target.sv
// Mode-0 SPI target, oversampled by clk: synchronized pins, rx/tx shift registers,
// and a one-word tx holding buffer that is loaded at frame start and after each word.
module spi_target #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         cpu_reset_n,
  spi_target_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic {StIdle, StActive} state_e;

  state_e            state_q, state_d;
  logic              sck_s1_q, sck_s2_q, sck_prev_q;
  logic              cs_s1_q, cs_s2_q, cs_prev_q;
  logic              mosi_s1_q, mosi_s2_q;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              reload_q, reload_d;
  logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [WIDTH-2:0]  rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;

  logic sck_rise, sck_fall, cs_fall, load;

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q & sck_prev_q;
  // Only a falling edge seen after a genuine high sample after reset starts a frame;
  // the reset value of the cs stages must not fake one when cs_n is already low.
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s2_q;

  always_comb begin
    state_d     = state_q;
    settle_d    = {settle_q[0], 1'b1};
    armed_d     = armed_q | (settle_q[1] & cs_s2_q);
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d  = StActive;
          cnt_d    = '0;
          reload_d = 1'b0;
          load     = 1'b1;
        end
      end
      StActive: begin
        if (cs_s2_q) begin
          state_d  = StIdle;
          cnt_d    = '0;
          reload_d = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[WIDTH-3:0], mosi_s2_q};
            if (cnt_q == CntW'(WIDTH - 1)) begin
              cnt_d      = '0;
              rx_data_d  = {rx_shift_q, mosi_s2_q};
              rx_valid_d = 1'b1;
              reload_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          if (sck_fall) begin
            if (reload_q) begin
              load     = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b1};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '1;
        underrun_d = 1'b1;
      end
    end

    // A word offered in the same cycle as an empty-buffer load waits for the next load.
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!cpu_reset_n) begin
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_prev_q  <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      reload_q    <= 1'b0;
      tx_shift_q  <= '1;
      rx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sck_s1_q    <= bus.spi_sck;
      sck_s2_q    <= sck_s1_q;
      sck_prev_q  <= sck_s2_q;
      cs_s1_q     <= bus.spi_cs_n;
      cs_s2_q     <= cs_s1_q;
      cs_prev_q   <= cs_s2_q;
      mosi_s1_q   <= bus.spi_mosi;
      mosi_s2_q   <= mosi_s1_q;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.spi_miso    = tx_shift_q[WIDTH-1];
  assign bus.spi_miso_oe = ~cs_s2_q;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a mode-0 master with a transaction-level model of the rx word
// stream, the tx holding buffer and underrun count, plus directed literal cases.
module tb_spi_target;
  localparam int unsigned W = 8;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic cpu_reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_target_if #(.WIDTH(W)) bus ();

  spi_target #(.WIDTH(W)) dut (
    .clk         (clk),
    .cpu_reset_n (cpu_reset_n),
    .bus         (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_rx_data = 8'h00;
  bit         mdl_full = 1'b0;
  logic [7:0] mdl_buf = 8'h00;
  logic [7:0] cur_tx = 8'hFF;
  int         uru_exp = 0;
  int         uru_seen = 0;

  logic       rst_seen = 1'b0;
  logic [2:0] cs_hist = 3'b111;
  logic [2:0] rst_hist = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    rst_seen <= cpu_reset_n;
    cs_hist  <= {cs_hist[1:0], bus.spi_cs_n};
    rst_hist <= {rst_hist[1:0], cpu_reset_n};
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_seen) begin
      exp_rx_data = 8'h00;
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_underrun", bus.tx_underrun, 0);
      chk("rst_miso", bus.spi_miso, 1);
      chk("rst_miso_oe", bus.spi_miso_oe, 0);
      chk("rst_tx_ready", bus.tx_ready, 1);
    end else begin
      if (bus.rx_valid) begin
        if (rx_q.size() == 0) chk("rx_valid_spurious", 1, 0);
        else begin
          exp_rx_data = rx_q.pop_front();
          chk("rx_data", bus.rx_data, exp_rx_data);
        end
      end else begin
        chk("rx_data_hold", bus.rx_data, exp_rx_data);
      end
      if (bus.tx_underrun) uru_seen++;
      if (rst_hist == 3'b111 && (cs_hist == 3'b111 || cs_hist == 3'b000))
        chk("miso_oe", bus.spi_miso_oe, !cs_hist[0]);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A frame load takes the buffered word, or all-ones with an underrun
  function automatic logic [7:0] model_load();
    if (mdl_full) begin
      mdl_full = 1'b0;
      return mdl_buf;
    end
    uru_exp++;
    return 8'hFF;
  endfunction

  task automatic offer(input logic [7:0] d);
    chk("tx_ready_offer", bus.tx_ready, !mdl_full);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_n(1);
    bus.tx_valid = 1'b0;
    if (!mdl_full) begin
      mdl_full = 1'b1;
      mdl_buf  = d;
    end
    chk("tx_ready_after_offer", bus.tx_ready, 0);
  endtask

  task automatic start_frame();
    bus.spi_cs_n = 1'b0;
    cur_tx = model_load();
    wait_n(HALF);
  endtask

  task automatic end_frame();
    wait_n(HALF + 2);
    chk("underruns", uru_seen, uru_exp);
  endtask

  task automatic do_word(input logic [7:0] m, input int nbits, input bit last,
                         input bit offer_mid, input logic [7:0] offer_d,
                         output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = m[7-i];
      if (i == 1) chk("tx_ready_mid", bus.tx_ready, !mdl_full);
      if (i == 3 && offer_mid) begin
        offer(offer_d);
        wait_n(HALF - 1);
      end else begin
        wait_n(HALF);
      end
      got[7-i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      if (i == 7) begin
        rx_q.push_back(m);
        wait_n(2);
        chk("rx_latency_early", bus.rx_valid, 0);
        wait_n(1);
        chk("rx_latency", bus.rx_valid, 1);
        wait_n(HALF - 3);
      end else begin
        wait_n(HALF);
      end
      bus.spi_sck = 1'b0;
      if (i == 7 && last) bus.spi_cs_n = 1'b1;
    end
    if (nbits == 8) begin
      chk("miso_word", got, cur_tx);
      if (!last) cur_tx = model_load();
    end else begin
      wait_n(HALF);
      bus.spi_cs_n = 1'b1;
    end
  endtask

  logic [7:0] got;

  initial begin
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    wait_n(3);
    cpu_reset_n = 1'b1;
    wait_n(4);
    chk("init_tx_ready", bus.tx_ready, 1);
    chk("init_miso", bus.spi_miso, 1);

    // Single word: tx A5, rx 3C
    offer(8'hA5);
    start_frame();
    do_word(8'h3C, 8, 1'b1, 1'b0, 8'h00, got);
    end_frame();
    chk("t1_miso_lit", got, 8'hA5);
    chk("t1_rx_lit", bus.rx_data, 8'h3C);
    chk("t1_uru_lit", uru_seen, 0);

    // Back-to-back words, second tx word offered mid-flight
    offer(8'h55);
    start_frame();
    do_word(8'h12, 8, 1'b0, 1'b1, 8'hAA, got);
    chk("t2_miso0_lit", got, 8'h55);
    do_word(8'h34, 8, 1'b1, 1'b0, 8'h00, got);
    chk("t2_miso1_lit", got, 8'hAA);
    end_frame();
    chk("t2_rx_lit", bus.rx_data, 8'h34);
    chk("t2_uru_lit", uru_seen, 0);

    // Empty buffer at cs fall, with a word offered in the very load cycle
    bus.spi_cs_n = 1'b0;
    cur_tx = model_load();
    wait_n(2);
    bus.tx_data  = 8'h6B;
    bus.tx_valid = 1'b1;
    wait_n(1);
    bus.tx_valid = 1'b0;
    mdl_full = 1'b1;
    mdl_buf  = 8'h6B;
    wait_n(HALF - 3);
    do_word(8'hE7, 8, 1'b0, 1'b0, 8'h00, got);
    chk("t3_miso0_lit", got, 8'hFF);
    do_word(8'h19, 8, 1'b1, 1'b0, 8'h00, got);
    chk("t3_miso1_lit", got, 8'h6B);
    end_frame();
    chk("t3_uru_lit", uru_seen, 1);
    chk("t3_rx_lit", bus.rx_data, 8'h19);

    // Aborted word after 5 bits, then a full frame
    offer(8'h11);
    start_frame();
    do_word(8'h81, 5, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    chk("t4_rx_hold_lit", bus.rx_data, 8'h19);
    start_frame();
    do_word(8'h7E, 8, 1'b1, 1'b0, 8'h00, got);
    end_frame();
    chk("t4_rx_lit", bus.rx_data, 8'h7E);
    chk("t4_uru_lit", uru_seen, 2);

    // Reset at bit 3, sck toggles with cs still low, then a fresh frame
    offer(8'h3A);
    start_frame();
    for (int i = 0; i < 3; i++) begin
      bus.spi_mosi = i[0];
      wait_n(HALF);
      bus.spi_sck = 1'b1;
      wait_n(HALF);
      bus.spi_sck = 1'b0;
    end
    wait_n(1);
    cpu_reset_n = 1'b0;
    mdl_full = 1'b0;
    wait_n(2);
    cpu_reset_n = 1'b1;
    chk("t5_rx_lit", bus.rx_data, 8'h00);
    for (int i = 0; i < 10; i++) begin
      bus.spi_mosi = 1'($urandom);
      wait_n(HALF);
      bus.spi_sck = ~bus.spi_sck;
    end
    bus.spi_sck = 1'b0;
    wait_n(HALF);
    chk("t5_oe_lit", bus.spi_miso_oe, 1);
    bus.spi_cs_n = 1'b1;
    wait_n(HALF + 2);
    offer(8'h5A);
    start_frame();
    do_word(8'hC3, 8, 1'b1, 1'b0, 8'h00, got);
    end_frame();
    chk("t5_miso_lit", got, 8'h5A);
    chk("t5_rx_after_lit", bus.rx_data, 8'hC3);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      int nw;
      if ($urandom_range(1, 0) == 1) offer(8'($urandom));
      start_frame();
      nw = int'($urandom_range(3, 1));
      for (int w = 0; w < nw; w++) begin
        bit last;
        int nb;
        last = (w == nw - 1);
        nb = ($urandom_range(5, 0) == 0) ? int'($urandom_range(7, 1)) : 8;
        do_word(8'($urandom), nb, last, 1'($urandom), 8'($urandom), got);
        if (nb != 8) break;
      end
      end_frame();
    end

    wait_n(10);
    chk("final_rx_queue_empty", rx_q.size(), 0);
    chk("final_underruns", uru_seen, uru_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
